mux_sel_arb: RTL and testbench

Sequential select generator that drives the 7-bit one-hot `opt` code consumed by the CPU's 32-bit two-input data-select muxes. Seven alternative data sources, such as HI/LO, CP0 and the multiply/divide result, request the mux's `b` path. The block arbitrates among them, holds the winning one-hot code for a fixed number of cycles, and acknowledges completion. It returns `opt` to all-zero between grants, which selects the default `a` path.

---
 rtl/mux_sel_pkg.sv | 24 ++
 rtl/mux_sel_arb_rr_pick7.sv | 29 ++
 rtl/mux_sel_arb.sv | 136 +++++++++++++
 tb/tb_mux_sel_arb.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the mux select arbiter.
// Rotating priority is enabled by defining MUX_SEL_RR_EN.
package mux_sel_pkg;

  localparam int unsigned NSRC = 7;
  localparam int unsigned IDXW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Convert a source index into the mux's one-hot select code.
  function automatic logic [NSRC-1:0] idx2onehot(input logic [IDXW-1:0] idx);
    logic [NSRC-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      oh[i] = (idx == IDXW'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/mux_sel_arb_rr_pick7.sv
// Combinational rotating-priority picker over seven requesters.
// Search starts at ptr and wraps 6->0; ptr tied to 0 gives fixed priority.
module rr_pick7
  import mux_sel_pkg::*;
(
  input  logic [NSRC-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  int unsigned pos;

  // Scan from the farthest offset down so the nearest request at/above ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned k = NSRC; k > 0; k--) begin
      pos = 32'(ptr) + k - 1;
      if (pos >= NSRC) pos = pos - NSRC;
      if (req[IDXW'(pos)]) begin
        valid = 1'b1;
        idx   = IDXW'(pos);
      end
    end
  end

endmodule

// File: rtl/mux_sel_arb.sv
// One-hot select generator for the 32-bit two-input data muxes.
// Arbitrates seven b-path sources, holds the grant HOLD cycles, acks, then
// returns to the a-path for one GAP cycle.
// Define MUX_SEL_RR_EN for rotating priority; otherwise req[0] has priority.
module mux_sel_arb
  import mux_sel_pkg::*;
#(
  parameter int unsigned HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] req,
  output logic [6:0] opt,
  output logic [2:0] gnt_idx,
  output logic [6:0] ack,
  output logic       busy
);

  localparam int unsigned CNTW = 4;
  localparam logic [CNTW-1:0] HOLD_M1 = CNTW'(HOLD - 1);

  state_e          state_q, state_d;
  logic [NSRC-1:0] opt_q, opt_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic [NSRC-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            pick_valid;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] pick_ptr;
  logic            owner_req;

`ifdef MUX_SEL_RR_EN
  logic [IDXW-1:0] ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = '0;
`endif

  rr_pick7 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // The grantee's request, read through the held one-hot code.
  assign owner_req = |(req & opt_q);

  // ack is registered, so it is loaded on the edge entering the last held
  // cycle; a request seen low on that edge is an abort and gets no ack.
  always_comb begin
    state_d   = state_q;
    opt_d     = opt_q;
    gnt_idx_d = gnt_idx_q;
    ack_d     = '0;
    cnt_d     = cnt_q;
`ifdef MUX_SEL_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        opt_d     = '0;
        gnt_idx_d = '0;
        if (pick_valid) begin
          state_d   = GRANT;
          opt_d     = idx2onehot(pick_idx);
          gnt_idx_d = pick_idx;
          cnt_d     = HOLD_M1;
          if (HOLD_M1 == '0) ack_d = idx2onehot(pick_idx);
`ifdef MUX_SEL_RR_EN
          ptr_d = (pick_idx == IDXW'(NSRC - 1)) ? '0 : pick_idx + 3'd1;
`endif
        end
      end
      GRANT: begin
        if (cnt_q == '0 || !owner_req) begin
          state_d   = GAP;
          opt_d     = '0;
          gnt_idx_d = '0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) ack_d = opt_q;
        end
      end
      GAP: begin
        state_d   = IDLE;
        opt_d     = '0;
        gnt_idx_d = '0;
        cnt_d     = '0;
      end
      default: begin
        state_d   = IDLE;
        opt_d     = '0;
        gnt_idx_d = '0;
        cnt_d     = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opt_q     <= '0;
      gnt_idx_q <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      opt_q     <= opt_d;
      gnt_idx_q <= gnt_idx_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef MUX_SEL_RR_EN
  // Rotating-priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign opt     = opt_q;
  assign gnt_idx = gnt_idx_q;
  assign ack     = ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mux_sel_arb.sv
// Directed self-checking bench for mux_sel_arb with HOLD = 1, 3 and 4.
module tb_mux_sel_arb;

  logic clk;
  logic rst_n;
  logic [6:0] req1, req3, req4;
  logic [6:0] opt1, opt3, opt4;
  logic [2:0] gi1, gi3, gi4;
  logic [6:0] ack1, ack3, ack4;
  logic busy1, busy3, busy4;

  int checks = 0;
  int errors = 0;

  mux_sel_arb #(.HOLD(1)) d1 (.clk(clk), .rst_n(rst_n), .req(req1), .opt(opt1), .gnt_idx(gi1), .ack(ack1), .busy(busy1));
  mux_sel_arb #(.HOLD(3)) d3 (.clk(clk), .rst_n(rst_n), .req(req3), .opt(opt3), .gnt_idx(gi3), .ack(ack3), .busy(busy3));
  mux_sel_arb #(.HOLD(4)) d4 (.clk(clk), .rst_n(rst_n), .req(req4), .opt(opt4), .gnt_idx(gi4), .ack(ack4), .busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req1 = '0; req3 = '0; req4 = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req1 = 7'h7F; req3 = 7'h7F; req4 = 7'h7F;
    tick(); tick();
    checks++; if (opt1 !== 7'h00) begin errors++; $display("FAIL rst_opt got=%b exp=%b", opt1, 7'h00); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy1); end
    rst_n = 1'b1;
    #1;
    checks++; if (opt1 !== 7'h00) begin errors++; $display("FAIL rel_opt got=%b exp=%b", opt1, 7'h00); end
    checks++; if (ack1 !== 7'h00) begin errors++; $display("FAIL rel_ack got=%b exp=%b", ack1, 7'h00); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rel_busy got=%b exp=0", busy1); end
    checks++; if (gi1 !== 3'd0) begin errors++; $display("FAIL rel_gnt got=%0d exp=0", gi1); end
    tick();
    checks++; if (opt1 !== 7'b0000001) begin errors++; $display("FAIL first_opt got=%b exp=%b", opt1, 7'b0000001); end
    checks++; if (ack1 !== 7'b0000001) begin errors++; $display("FAIL first_ack got=%b exp=%b", ack1, 7'b0000001); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL first_busy got=%b exp=1", busy1); end
    checks++; if (opt3 !== 7'b0000001) begin errors++; $display("FAIL first_opt3 got=%b exp=%b", opt3, 7'b0000001); end
    checks++; if (ack3 !== 7'b0000000) begin errors++; $display("FAIL first_ack3 got=%b exp=0", ack3); end
  endtask

  task automatic test_single_hold3();
    logic [6:0] exp_ack;
    do_reset();
    req3 = 7'b0000100;
    for (int c = 1; c <= 3; c++) begin
      tick();
      exp_ack = (c == 3) ? 7'b0000100 : 7'b0000000;
      checks++; if (opt3 !== 7'b0000100) begin errors++; $display("FAIL hold3_opt c=%0d got=%b exp=%b", c, opt3, 7'b0000100); end
      checks++; if (gi3 !== 3'd2) begin errors++; $display("FAIL hold3_gnt c=%0d got=%0d exp=2", c, gi3); end
      checks++; if (ack3 !== exp_ack) begin errors++; $display("FAIL hold3_ack c=%0d got=%b exp=%b", c, ack3, exp_ack); end
    end
    req3 = '0;
    tick();
    checks++; if (opt3 !== 7'h00) begin errors++; $display("FAIL hold3_gap_opt got=%b exp=0", opt3); end
    checks++; if (ack3 !== 7'h00) begin errors++; $display("FAIL hold3_gap_ack got=%b exp=0", ack3); end
    checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL hold3_gap_busy got=%b exp=1", busy3); end
    tick();
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL hold3_idle_busy got=%b exp=0", busy3); end
  endtask

  task automatic test_priority();
    logic [6:0] exp_opt;
    logic [2:0] exp_idx;
    do_reset();
`ifdef MUX_SEL_RR_EN
    req1 = 7'h7F;
`else
    req1 = 7'b1000010;
`endif
    for (int g = 0; g < 8; g++) begin
`ifdef MUX_SEL_RR_EN
      exp_idx = 3'(g % 7);
`else
      exp_idx = 3'd1;
`endif
      exp_opt = 7'd1 << exp_idx;
      tick();
      checks++; if (opt1 !== exp_opt) begin errors++; $display("FAIL prio_opt g=%0d got=%b exp=%b", g, opt1, exp_opt); end
      checks++; if (gi1 !== exp_idx) begin errors++; $display("FAIL prio_gnt g=%0d got=%0d exp=%0d", g, gi1, exp_idx); end
      checks++; if (ack1 !== exp_opt) begin errors++; $display("FAIL prio_ack g=%0d got=%b exp=%b", g, ack1, exp_opt); end
      tick();
      checks++; if (opt1 !== 7'h00 || busy1 !== 1'b1) begin errors++; $display("FAIL prio_gap g=%0d got opt=%b busy=%b exp opt=0 busy=1", g, opt1, busy1); end
      tick();
      checks++; if (opt1 !== 7'h00 || busy1 !== 1'b0) begin errors++; $display("FAIL prio_idle g=%0d got opt=%b busy=%b exp opt=0 busy=0", g, opt1, busy1); end
    end
  endtask

  task automatic test_abort();
    logic [6:0] exp_opt;
    do_reset();
    req4 = 7'b0100000;
    tick();
    checks++; if (opt4 !== 7'b0100000 || gi4 !== 3'd5) begin errors++; $display("FAIL abort_grant got opt=%b gnt=%0d exp opt=0100000 gnt=5", opt4, gi4); end
    tick();
    checks++; if (opt4 !== 7'b0100000 || ack4 !== 7'h00) begin errors++; $display("FAIL abort_hold got opt=%b ack=%b exp opt=0100000 ack=0", opt4, ack4); end
    req4 = '0;
    tick();
    checks++; if (opt4 !== 7'h00 || ack4 !== 7'h00 || busy4 !== 1'b1) begin errors++; $display("FAIL abort_gap got opt=%b ack=%b busy=%b exp 0,0,1", opt4, ack4, busy4); end
    tick();
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b exp=0", busy4); end
    req4 = 7'h7F;
`ifdef MUX_SEL_RR_EN
    exp_opt = 7'b1000000;
`else
    exp_opt = 7'b0000001;
`endif
    tick();
    checks++; if (opt4 !== exp_opt) begin errors++; $display("FAIL abort_next got=%b exp=%b", opt4, exp_opt); end
    // Drop on the edge where the counter would reach zero: no ack.
    do_reset();
    req4 = 7'b0001000;
    tick(); tick(); tick();
    checks++; if (opt4 !== 7'b0001000 || ack4 !== 7'h00) begin errors++; $display("FAIL late_hold got opt=%b ack=%b exp opt=0001000 ack=0", opt4, ack4); end
    req4 = '0;
    tick();
    checks++; if (opt4 !== 7'h00 || ack4 !== 7'h00 || busy4 !== 1'b1) begin errors++; $display("FAIL late_abort got opt=%b ack=%b busy=%b exp 0,0,1", opt4, ack4, busy4); end
  endtask

  task automatic test_gap_request();
    do_reset();
    req1 = 7'b0001000;
    tick();
    checks++; if (opt1 !== 7'b0001000 || ack1 !== 7'b0001000) begin errors++; $display("FAIL gapreq_grant got opt=%b ack=%b exp 0001000", opt1, ack1); end
    tick();
    req1 = 7'b0000001;
    tick();
    checks++; if (opt1 !== 7'h00) begin errors++; $display("FAIL gapreq_idle got=%b exp=0", opt1); end
    tick();
    checks++; if (opt1 !== 7'b0000001) begin errors++; $display("FAIL gapreq_rise got=%b exp=0000001", opt1); end
    tick();
    req1 = '0;
    tick(); tick();
    checks++; if (opt1 !== 7'h00 || busy1 !== 1'b0) begin errors++; $display("FAIL gapreq_fall got opt=%b busy=%b exp 0,0", opt1, busy1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req4 = 7'b0000010;
    req1 = 7'b0000010;
    tick();
    checks++; if (opt4 !== 7'b0000010 || ack1 !== 7'b0000010) begin errors++; $display("FAIL areset_pre got opt4=%b ack1=%b exp 0000010", opt4, ack1); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (opt4 !== 7'h00 || busy4 !== 1'b0 || gi4 !== 3'd0) begin errors++; $display("FAIL areset_d4 got opt=%b busy=%b gnt=%0d exp 0", opt4, busy4, gi4); end
    checks++; if (opt1 !== 7'h00 || ack1 !== 7'h00 || busy1 !== 1'b0) begin errors++; $display("FAIL areset_d1 got opt=%b ack=%b busy=%b exp 0", opt1, ack1, busy1); end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_hold3();
    test_priority();
    test_abort();
    test_gap_request();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
